ascii_case_converter: RTL and testbench
=======================================

ASCII_CASE_CONVERTER -- requirements
Module: ascii_case_converter

Interface
REQ-001 Parameter LANES, default 1, meaning ASCII characters per data beat (1..8).
REQ-002 Parameter DEPTH, default 4, meaning output FIFO entries (power of 2, 2..16).
REQ-003 Parameter CNT_W, default 16, meaning width of the converted-character counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  2  00 pass-through, 01 to-upper, 10 to-lower, 11 toggle case.
REQ-007 in_valid  input  1  in_data holds a beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  8*LANES  characters; lane k at bits [8k+7:8k].
REQ-010 out_valid  output  1  out_data holds a converted beat.
REQ-011 out_ready  input  1  downstream consumes the beat this cycle.
REQ-012 out_data  output  8*LANES  converted characters, same lane order.
REQ-013 conv_count  output  CNT_W  running count of characters whose value was changed.
REQ-014 clr_count  input  1  synchronous clear of conv_count.

Function
REQ-015 Beat accepted when in_valid && in_ready at a rising edge; beat emitted when out_valid && out_ready.
REQ-016 in_ready SHALL equal "FIFO not full"; it does not depend combinationally on out_ready.
REQ-017 mode SHALL be sampled per beat at acceptance; mode changes never alter beats already stored.
REQ-018 Per lane, lowercase = 0x61..0x7A, uppercase = 0x41..0x5A; all other byte values (incl. 0x80..0xFF) pass unchanged in every mode.
REQ-019 To-upper: lowercase byte minus 0x20; to-lower: uppercase byte plus 0x20; toggle: either range flipped by XOR 0x20.
REQ-020 Boundary bytes: 0x40, 0x5B, 0x60, 0x7B SHALL be unchanged in all modes.
REQ-021 Conversion result SHALL be written into the FIFO at the acceptance edge; latency accept-to-out_valid is exactly 1 cycle when FIFO was empty.
REQ-022 FIFO order strictly first-in first-out; out_data stable while out_valid && !out_ready.
REQ-023 Occupancy: push only -> +1; pop only -> -1; push and pop same edge -> unchanged, both performed (allowed whenever not full, incl. occupancy 1).
REQ-024 When full, in_ready low; a pop on that edge re-asserts in_ready next cycle, no same-cycle bypass.
REQ-025 Pointers wrap modulo DEPTH; occupancy held in log2(DEPTH)+1 bits.
REQ-026 conv_count SHALL add, at each acceptance edge, the number of lanes in that beat whose value changed (0..LANES).
REQ-027 conv_count wraps modulo 2^CNT_W; no saturation.
REQ-028 clr_count high at an edge SHALL set conv_count to the count of that edge's accepted beat only (clear then add).
REQ-029 Pass-through beats add 0 to conv_count.

Reset
REQ-030 rst_n low SHALL immediately force: FIFO empty, pointers 0, out_valid 0, in_ready 0, conv_count 0, out_data 0.
REQ-031 in_ready SHALL rise on the first rising clk edge after rst_n deasserts; no beat accepted before then.
REQ-032 Reset asserted mid-stream SHALL discard all stored beats; none appear after reset release.

Verification
REQ-033 LANES=1, mode=01, feed 0x61,0x7A,0x41,0x7B, out_ready=1 -> out 0x41,0x5A,0x41,0x7B, each 1 cycle after accept; conv_count=2.
REQ-034 LANES=4, mode=11, in_data 0x61_5A_40_31 (lanes 3..0) -> out_data 0x41_7A_40_31; conv_count +2.
REQ-035 DEPTH=4, out_ready=0, stream 6 beats -> 4 accepted, in_ready low after 4th; then out_ready=1 -> 4 beats in order, in_ready high 1 cycle after first pop.
REQ-036 mode switched 01->10 while 3 beats 0x61 queued, then accept 0x41 -> outputs 0x41,0x41,0x41,0x61.
REQ-037 Occupancy 2, push+pop same edge -> occupancy stays 2, order preserved; conv_count at 0xFFFF plus 1 change (CNT_W=16) -> 0x0000.
REQ-038 rst_n pulsed low for half a cycle with 3 beats stored -> out_valid 0 asynchronously, conv_count 0, no stale beats after release.

Source files
------------

// File: rtl/ascii_case_converter.sv
// ---------------------------------------------------------------------------
// ascii_case_converter
//
// Streaming ASCII case converter. Each accepted beat carries LANES bytes. Each
// byte is converted with the mode sampled at acceptance, and the result is
// written into a DEPTH-entry FIFO on that same edge. A running counter
// accumulates how many bytes were actually changed.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   mode[1:0]    00 pass, 01 to-upper, 10 to-lower, 11 toggle case
//   in_valid     upstream beat present
//   in_ready     FIFO has room (registered state only, no path from out_ready)
//   in_data      LANES bytes, lane k at [8k+7:8k]
//   out_valid    FIFO not empty
//   out_ready    downstream consumes head beat
//   out_data     head beat of FIFO (zero while empty)
//   conv_count   running count of changed bytes, wraps modulo 2^CNT_W
//   clr_count    synchronous clear; the beat accepted on that edge still adds
// ---------------------------------------------------------------------------
module ascii_case_converter #(
    parameter int LANES = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]     conv_count,
    input  logic                 clr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_LOWER = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // Letter ranges differ only in bit 5, so every conversion is a flip of
    // bit 5 on bytes that fall inside the range the mode acts on.
    function automatic logic [7:0] conv_byte(input logic [7:0] c, input logic [1:0] m);
        logic is_lower;
        logic is_upper;
        logic flip;
        is_lower = (c >= 8'h61) && (c <= 8'h7A);
        is_upper = (c >= 8'h41) && (c <= 8'h5A);
        case (m)
            MODE_UPPER:  flip = is_lower;
            MODE_LOWER:  flip = is_upper;
            MODE_TOGGLE: flip = is_lower || is_upper;
            default:     flip = 1'b0;
        endcase
        return c ^ {2'b00, flip, 5'b00000};
    endfunction

    logic [8*LANES-1:0] conv_data;
    logic [LANES-1:0]   lane_chg;
    logic [CNT_W-1:0]   chg_cnt;

    logic [8*LANES-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               started;
    logic               push;
    logic               pop;
    logic               full;

    always_comb begin
        conv_data = '0;
        lane_chg  = '0;
        for (int k = 0; k < LANES; k++) begin
            conv_data[8*k +: 8] = conv_byte(in_data[8*k +: 8], mode);
            lane_chg[k]         = (conv_data[8*k +: 8] != in_data[8*k +: 8]);
        end
    end

    always_comb begin
        chg_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_chg[k]) begin
                chg_cnt = chg_cnt + CNT_W'(1);
            end
        end
    end

    // in_ready is held low until the first edge after reset release.
    assign full      = (count == FULL_CNT);
    assign in_ready  = started && !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; the read side is gated so a cleared FIFO shows 0.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= conv_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            started <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count <= '0;
        end else begin
            conv_count <= (clr_count ? '0 : conv_count) + (push ? chg_cnt : '0);
        end
    end

endmodule

// File: tb/tb_ascii_case_converter.sv
module tb_ascii_case_converter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        clr_count;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]  in_data1, out_data1;
    logic [15:0] conv_count1;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] in_data4, out_data4;
    logic [15:0] conv_count4;

    int n_vec;
    int n_err;

    logic [31:0] q[$];
    logic [15:0] m_cnt;
    logic        m_rdy;

    ascii_case_converter #(.LANES(1), .DEPTH(DEPTH), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .conv_count(conv_count1), .clr_count(clr_count)
    );

    ascii_case_converter #(.LANES(4), .DEPTH(DEPTH), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .conv_count(conv_count4), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion: letters move by 32 within the code table.
    task automatic ref_conv(input logic [31:0] d, input logic [1:0] m,
                            output logic [31:0] r, output int nchg);
        int b;
        int nb;
        nchg = 0;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b  = int'(d[8*k +: 8]);
            nb = b;
            if ((m == 2'd1 || m == 2'd3) && b >= 97 && b <= 122) nb = b - 32;
            else if ((m == 2'd2 || m == 2'd3) && b >= 65 && b <= 90) nb = b + 32;
            if (nb != b) nchg++;
            r[8*k +: 8] = 8'(nb);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] bnd [4];
        bnd = '{8'h40, 8'h5B, 8'h60, 8'h7B};
        case ($urandom_range(0, 3))
            0:       return 8'(8'h61 + $urandom_range(0, 25));
            1:       return 8'(8'h41 + $urandom_range(0, 25));
            2:       return bnd[$urandom_range(0, 3)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [31:0] rnd_beat();
        return {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
    endfunction

    // One clock: check the 4-lane instance against the model at the falling
    // edge, then advance the model across the rising edge. Returns at edge+1.
    task automatic cycle();
        logic        push;
        logic        pop;
        logic        clr;
        logic [31:0] cv;
        int          nchg;
        @(negedge clk);
        chk("in_ready", in_ready4, m_rdy && (q.size() < DEPTH));
        chk("out_valid", out_valid4, q.size() > 0);
        if (q.size() > 0) chk("out_data", out_data4, q[0]);
        chk("conv_count", conv_count4, m_cnt);
        push = in_valid4 && m_rdy && (q.size() < DEPTH);
        pop  = out_ready4 && (q.size() > 0);
        clr  = clr_count;
        ref_conv(in_data4, mode, cv, nchg);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(cv);
        m_cnt = (clr ? 16'd0 : m_cnt) + (push ? 16'(nchg) : 16'd0);
        m_rdy = (rst_n === 1'b1);
        #1;
    endtask

    logic [7:0]  seq_in  [4];
    logic [7:0]  seq_exp [4];
    logic [31:0] exp36   [4];

    initial begin
        n_vec = 0; n_err = 0;
        m_cnt = '0; m_rdy = 1'b0;
        seq_in  = '{8'h61, 8'h7A, 8'h41, 8'h7B};
        seq_exp = '{8'h41, 8'h5A, 8'h41, 8'h7B};
        exp36   = '{32'h41414141, 32'h41414141, 32'h41414141, 32'h61616161};
        mode = 2'b00; clr_count = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        rst_n = 1'b0;

        // Reset values
        #1;
        chk("rst_in_ready1", in_ready1, 1'b0);
        chk("rst_out_valid1", out_valid1, 1'b0);
        chk("rst_out_data1", out_data1, 8'h00);
        chk("rst_cnt1", conv_count1, 16'h0);
        chk("rst_in_ready4", in_ready4, 1'b0);
        chk("rst_out_data4", out_data4, 32'h0);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_before_edge", in_ready4, 1'b0);
        @(posedge clk); #1;
        m_rdy = 1'b1;
        chk("in_ready_after_edge1", in_ready1, 1'b1);
        chk("in_ready_after_edge4", in_ready4, 1'b1);

        // Single-lane to-upper stream, one-cycle latency
        mode = 2'b01; out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1'b1; in_data1 = seq_in[i];
            if (i == 0) chk("u1_valid_before", out_valid1, 1'b0);
            cycle();
            in_valid1 = 1'b0;
            #2;
            chk("u1_valid_lat", out_valid1, 1'b1);
            chk("u1_data", out_data1, seq_exp[i]);
        end
        cycle();
        chk("u1_drained", out_valid1, 1'b0);
        chk("u1_count", conv_count1, 16'd2);

        // Four lanes, toggle
        mode = 2'b11; in_valid4 = 1'b1; in_data4 = 32'h615A4031; out_ready4 = 1'b0;
        cycle();
        in_valid4 = 1'b0;
        chk("toggle_lanes", out_data4, 32'h417A4031);
        chk("toggle_count", conv_count4, 16'd2);
        out_ready4 = 1'b1;
        cycle();

        // Fill to full, then drain; no bypass on the freeing edge
        mode = 2'b01; out_ready4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data4 = rnd_beat();
            cycle();
        end
        chk("full_in_ready", in_ready4, 1'b0);
        out_ready4 = 1'b1; in_data4 = rnd_beat();
        cycle();
        in_valid4 = 1'b0;
        chk("ready_after_pop", in_ready4, 1'b1);
        for (int i = 0; i < 4; i++) cycle();

        // Mode change does not touch stored beats
        out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = 32'h61616161;
        for (int i = 0; i < 3; i++) cycle();
        mode = 2'b10; in_data4 = 32'h41414141;
        cycle();
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mode_stored", out_data4, exp36[i]);
            cycle();
        end
        cycle();

        // Occupancy 2 with simultaneous push and pop
        mode = 2'b11; out_ready4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 2; i++) begin in_data4 = rnd_beat(); cycle(); end
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data4 = rnd_beat(); cycle(); end
        out_ready4 = 1'b0;
        in_data4 = rnd_beat(); cycle();
        chk("occ3_not_full", in_ready4, 1'b1);
        in_data4 = rnd_beat(); cycle();
        chk("occ4_full", in_ready4, 1'b0);
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Clear then add, and counter wrap
        mode = 2'b01; in_valid4 = 1'b1; clr_count = 1'b1; in_data4 = 32'h61613131;
        cycle();
        clr_count = 1'b0;
        chk("clr_then_add", conv_count4, 16'd2);
        clr_count = 1'b1; in_data4 = 32'h31313131;
        cycle();
        clr_count = 1'b0;
        chk("clr_zero", conv_count4, 16'd0);
        in_data4 = 32'h61616161;
        for (int i = 0; i < 16383; i++) cycle();
        in_data4 = 32'h61616131;
        cycle();
        chk("cnt_ffff", conv_count4, 16'hFFFF);
        in_data4 = 32'h31313161;
        cycle();
        chk("cnt_wrap", conv_count4, 16'h0000);
        in_valid4 = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            mode       = 2'($urandom_range(0, 3));
            in_valid4  = 1'($urandom_range(0, 1));
            out_ready4 = 1'($urandom_range(0, 2) != 0);
            clr_count  = ($urandom_range(0, 15) == 0);
            in_data4   = rnd_beat();
            cycle();
        end
        clr_count = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Short reset pulse with beats stored
        out_ready4 = 1'b0; in_valid4 = 1'b1; mode = 2'b01;
        for (int i = 0; i < 3; i++) begin in_data4 = rnd_beat(); cycle(); end
        in_valid4 = 1'b0;
        chk("pre_rst_valid", out_valid4, 1'b1);
        rst_n = 1'b0;
        q.delete(); m_cnt = '0; m_rdy = 1'b0;
        #1;
        chk("async_valid", out_valid4, 1'b0);
        chk("async_ready", in_ready4, 1'b0);
        chk("async_cnt", conv_count4, 16'h0);
        chk("async_data", out_data4, 32'h0);
        #2 rst_n = 1'b1;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("no_stale", out_valid4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
